// File: rtl/riscv_pkg.sv
// Shared pipeline constants for the RISC-V core: forwarding mux selects and
// the default register-address width.
package riscv_pkg;

  localparam int REG_AW_DEFAULT = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/riscv_hazard_fwd.sv
// Per-operand forwarding select: picks the youngest in-flight producer of the
// Execute-stage source register. x0 is never forwarded.
module riscv_hazard_fwd
  import riscv_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] irs_e,
  input  logic [REG_AW-1:0] ird_m,
  input  logic [REG_AW-1:0] ird_w,
  input  logic              iwr_en_m,
  input  logic              iwr_en_w,
  output logic [1:0]        ofwd
);

  always_comb begin
    ofwd = FWD_RF;
    if (iwr_en_m && (ird_m == irs_e) && (irs_e != '0)) begin
      ofwd = FWD_MEM;
    end else if (iwr_en_w && (ird_w == irs_e) && (irs_e != '0)) begin
      ofwd = FWD_WB;
    end
  end

endmodule

// File: rtl/riscv_hazard.sv
// Hazard unit for the 5-stage core: forwarding selects, load-use stall,
// branch flush, and saturating stall/flush performance counters.
module riscv_hazard
  import riscv_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic [REG_AW-1:0] irs1_d,
  input  logic [REG_AW-1:0] irs2_d,
  input  logic [REG_AW-1:0] ird_d,
  input  logic              iresult_srcb0,
  input  logic              ipc_src,
  input  logic              ird_wr_en_1d,
  input  logic              ird_wr_en_2d,
  input  logic              iclr_cnt,
  output logic [1:0]        ofwd_a_e,
  output logic [1:0]        ofwd_b_e,
  output logic              ostall_f,
  output logic              ostall_d,
  output logic              oflush_d,
  output logic              oflush_e,
  output logic [CNT_W-1:0]  ostall_cnt,
  output logic [CNT_W-1:0]  oflush_cnt
);

  logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
  logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
  logic [REG_AW-1:0] rd_e_q, rd_e_d;
  logic [REG_AW-1:0] rd_m_q;
  logic [REG_AW-1:0] rd_w_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic              lw_stall;
  logic              stall;
  logic              flush_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A taken branch overrides the load-use stall so fetch moves to the target.
  assign lw_stall = iresult_srcb0 && (rd_e_q != '0) &&
                    ((rd_e_q == irs1_d) || (rd_e_q == irs2_d));
  assign stall    = lw_stall && !ipc_src;
  assign flush_e  = lw_stall || ipc_src;

  assign ostall_f   = stall;
  assign ostall_d   = stall;
  assign oflush_d   = ipc_src;
  assign oflush_e   = flush_e;
  assign ostall_cnt = stall_cnt_q;
  assign oflush_cnt = flush_cnt_q;

  always_comb begin
    rs1_e_d = irs1_d;
    rs2_e_d = irs2_d;
    rd_e_d  = ird_d;
    if (flush_e) begin
      rs1_e_d = '0;
      rs2_e_d = '0;
      rd_e_d  = '0;
    end
  end

  // D/E, E/M, M/W address stages
  always_ff @(posedge iclk) begin
    if (irst) begin
      rs1_e_q <= '0;
      rs2_e_q <= '0;
      rd_e_q  <= '0;
      rd_m_q  <= '0;
      rd_w_q  <= '0;
    end else begin
      rs1_e_q <= rs1_e_d;
      rs2_e_q <= rs2_e_d;
      rd_e_q  <= rd_e_d;
      rd_m_q  <= rd_e_q;
      rd_w_q  <= rd_m_q;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst || iclr_cnt) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst || iclr_cnt) begin
      flush_cnt_q <= '0;
    end else if (ipc_src) begin
      flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  riscv_hazard_fwd #(.REG_AW(REG_AW)) u_fwd_a (
    .irs_e    (rs1_e_q),
    .ird_m    (rd_m_q),
    .ird_w    (rd_w_q),
    .iwr_en_m (ird_wr_en_1d),
    .iwr_en_w (ird_wr_en_2d),
    .ofwd     (ofwd_a_e)
  );

  riscv_hazard_fwd #(.REG_AW(REG_AW)) u_fwd_b (
    .irs_e    (rs2_e_q),
    .ird_m    (rd_m_q),
    .ird_w    (rd_w_q),
    .iwr_en_m (ird_wr_en_1d),
    .iwr_en_w (ird_wr_en_2d),
    .ofwd     (ofwd_b_e)
  );

endmodule
